// File: rtl/sys_array_leaf_scheduler.sv
// rtl/sys_array_leaf_scheduler.sv - depth-first split-tree walker emitting leaf tile tasks
//
// Walks the split table from root node 0, children to_n1 before to_n2, and
// hands one tile task per leaf (operation == connect_none) to the systolic
// array controller. task_acc marks leaves under a connect_sum split so their
// partial sums are added into the output region.
//
// tbl_rdata layout (242 bits, 16-bit fields, LSB first):
//   [15:0] A_W_0  [31:16] A_W_1  [47:32] A_L_0  [63:48] A_L_1
//   [79:64] B_W_0 [95:80] B_W_1  [111:96] B_L_0 [127:112] B_L_1
//   [143:128] O_W_0 [159:144] O_W_1 [175:160] O_L_0 [191:176] O_L_1
//   [193:192] operation (0 none, 1 vert, 2 hor, 3 sum)
//   [209:194] to_n1  [225:210] to_n2  [241:226] parent
//
// Ports:
//   clk, reset               clock, asynchronous active-high reset
//   start, split_ready       traversal request, table-complete qualifier
//   split_last               number of valid table entries
//   tbl_addr / tbl_rdata     table read port (data valid the cycle after addr)
//   task_*                   leaf task with valid/ready handshake
//   busy, done, error        traversal status (done/error held)
//   leaf_count               tasks accepted in this traversal
module sys_array_leaf_scheduler #(
  parameter int TABLE_SIZE  = 100,
  parameter int STACK_DEPTH = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         split_ready,
  input  logic [15:0]  split_last,
  output logic [15:0]  tbl_addr,
  input  logic [241:0] tbl_rdata,
  output logic         task_valid,
  input  logic         task_ready,
  output logic [15:0]  task_node,
  output logic [15:0]  task_a_row0,
  output logic [15:0]  task_a_col0,
  output logic [15:0]  task_b_row0,
  output logic [15:0]  task_b_col0,
  output logic [15:0]  task_o_row0,
  output logic [15:0]  task_o_col0,
  output logic [15:0]  task_rows,
  output logic [15:0]  task_inner,
  output logic [15:0]  task_cols,
  output logic         task_acc,
  output logic         busy,
  output logic         done,
  output logic         error,
  output logic [15:0]  leaf_count
);

  localparam int SPW = $clog2(STACK_DEPTH + 1);
  localparam int IW  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  localparam logic [1:0] OP_NONE = 2'd0;
  localparam logic [1:0] OP_SUM  = 2'd3;

  typedef enum logic [2:0] {S_IDLE, S_POP, S_EVAL, S_EMIT, S_DONE} state_t;

  state_t         state_q;
  logic [16:0]    stack_q [STACK_DEPTH];  // {node index, acc}
  logic [SPW-1:0] sp_q;
  logic [15:0]    tbl_addr_q;
  logic           acc_q;
  logic [15:0]    node_q, a_row0_q, a_col0_q, b_row0_q, b_col0_q, o_row0_q, o_col0_q;
  logic [15:0]    rows_q, inner_q, cols_q, leaf_count_q;
  logic           task_valid_q, task_acc_q, busy_q, done_q, error_q;

  // Table entry fields
  logic [15:0] a_w0, a_w1, a_l0, a_l1, b_w0, b_l0, b_l1, o_w0, o_l0, to_n1, to_n2;
  logic [1:0]  op;
  logic        unused_fields;

  assign a_w0  = tbl_rdata[0   +: 16];
  assign a_w1  = tbl_rdata[16  +: 16];
  assign a_l0  = tbl_rdata[32  +: 16];
  assign a_l1  = tbl_rdata[48  +: 16];
  assign b_w0  = tbl_rdata[64  +: 16];
  assign b_l0  = tbl_rdata[96  +: 16];
  assign b_l1  = tbl_rdata[112 +: 16];
  assign o_w0  = tbl_rdata[128 +: 16];
  assign o_l0  = tbl_rdata[160 +: 16];
  assign op    = tbl_rdata[193:192];
  assign to_n1 = tbl_rdata[194 +: 16];
  assign to_n2 = tbl_rdata[210 +: 16];
  assign unused_fields = ^{tbl_rdata[80 +: 16], tbl_rdata[144 +: 16],
                           tbl_rdata[176 +: 16], tbl_rdata[226 +: 16]};

  logic [16:0] top_entry;
  logic        bad_index, bad_child, no_room;

  assign top_entry = stack_q[IW'(sp_q - 1'b1)];
  assign bad_index = (tbl_addr_q >= split_last) || (tbl_addr_q >= 16'(TABLE_SIZE));
  assign bad_child = (to_n1 >= split_last) || (to_n2 >= split_last);
  // Two pushes follow an internal node, so at most STACK_DEPTH-2 may be held.
  assign no_room   = sp_q > SPW'(STACK_DEPTH - 2);

  // The popped index is presented combinationally during POP so a synchronous
  // table RAM returns the entry in EVAL; elsewhere the last address is held.
  assign tbl_addr = (state_q == S_POP && sp_q != '0) ? top_entry[16:1] : tbl_addr_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      sp_q         <= '0;
      tbl_addr_q   <= '0;
      acc_q        <= 1'b0;
      node_q       <= '0;
      a_row0_q     <= '0;
      a_col0_q     <= '0;
      b_row0_q     <= '0;
      b_col0_q     <= '0;
      o_row0_q     <= '0;
      o_col0_q     <= '0;
      rows_q       <= '0;
      inner_q      <= '0;
      cols_q       <= '0;
      leaf_count_q <= '0;
      task_valid_q <= 1'b0;
      task_acc_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      for (int i = 0; i < STACK_DEPTH; i++) stack_q[i] <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start && split_ready) begin
            stack_q[0]   <= 17'd0;
            sp_q         <= SPW'(1);
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            leaf_count_q <= '0;
            busy_q       <= 1'b1;
            state_q      <= S_POP;
          end
        end
        S_POP: begin
          if (sp_q == '0) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            sp_q       <= sp_q - 1'b1;
            tbl_addr_q <= top_entry[16:1];
            acc_q      <= top_entry[0];
            state_q    <= S_EVAL;
          end
        end
        S_EVAL: begin
          if (bad_index) begin
            error_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else if (op == OP_NONE) begin
            node_q       <= tbl_addr_q;
            a_row0_q     <= a_w0;
            a_col0_q     <= a_l0;
            b_row0_q     <= b_w0;
            b_col0_q     <= b_l0;
            o_row0_q     <= o_w0;
            o_col0_q     <= o_l0;
            rows_q       <= a_w1 - a_w0 + 16'd1;
            inner_q      <= a_l1 - a_l0 + 16'd1;
            cols_q       <= b_l1 - b_l0 + 16'd1;
            task_acc_q   <= acc_q;
            task_valid_q <= 1'b1;
            state_q      <= S_EMIT;
          end else if (bad_child || no_room) begin
            error_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            // to_n2 goes in first so to_n1 sits on top and is visited first.
            stack_q[IW'(sp_q)]        <= {to_n2, acc_q | (op == OP_SUM)};
            stack_q[IW'(sp_q + 1'b1)] <= {to_n1, acc_q};
            sp_q                      <= sp_q + SPW'(2);
            state_q                   <= S_POP;
          end
        end
        S_EMIT: begin
          if (task_ready) begin
            task_valid_q <= 1'b0;
            leaf_count_q <= leaf_count_q + 16'd1;
            state_q      <= S_POP;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign task_valid  = task_valid_q;
  assign task_node   = node_q;
  assign task_a_row0 = a_row0_q;
  assign task_a_col0 = a_col0_q;
  assign task_b_row0 = b_row0_q;
  assign task_b_col0 = b_col0_q;
  assign task_o_row0 = o_row0_q;
  assign task_o_col0 = o_col0_q;
  assign task_rows   = rows_q;
  assign task_inner  = inner_q;
  assign task_cols   = cols_q;
  assign task_acc    = task_acc_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign error       = error_q;
  assign leaf_count  = leaf_count_q;

endmodule

// File: tb/tb_sys_array_leaf_scheduler.sv
// tb/tb_sys_array_leaf_scheduler.sv - scoreboard bench for sys_array_leaf_scheduler
module tb_sys_array_leaf_scheduler;

  localparam logic [1:0] NONE = 2'd0, VERT = 2'd1, HOR = 2'd2, SUM = 2'd3;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic         split_ready = 1'b1;
  logic [15:0]  split_last = '0;
  logic [15:0]  tbl_addr;
  logic [241:0] rdata = '0;
  logic         task_valid;
  logic         task_ready = 1'b1;
  logic [15:0]  task_node, task_a_row0, task_a_col0, task_b_row0, task_b_col0;
  logic [15:0]  task_o_row0, task_o_col0, task_rows, task_inner, task_cols;
  logic         task_acc, busy, done, error;
  logic [15:0]  leaf_count;

  logic [241:0] mem [0:63];
  int           n_vec = 0;
  int           n_miss = 0;
  bit           rand_ready = 1'b0;

  typedef struct { logic [15:0] node; logic acc; } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  sys_array_leaf_scheduler dut (
    .clk(clk), .reset(reset), .start(start), .split_ready(split_ready),
    .split_last(split_last), .tbl_addr(tbl_addr), .tbl_rdata(rdata),
    .task_valid(task_valid), .task_ready(task_ready), .task_node(task_node),
    .task_a_row0(task_a_row0), .task_a_col0(task_a_col0),
    .task_b_row0(task_b_row0), .task_b_col0(task_b_col0),
    .task_o_row0(task_o_row0), .task_o_col0(task_o_col0),
    .task_rows(task_rows), .task_inner(task_inner), .task_cols(task_cols),
    .task_acc(task_acc), .busy(busy), .done(done), .error(error),
    .leaf_count(leaf_count)
  );

  // Synchronous table RAM: entry returned the cycle after the address.
  always @(posedge clk) rdata <= mem[tbl_addr[5:0]];

  always @(posedge clk) begin
    #1;
    if (rand_ready) task_ready = ($urandom_range(0, 2) != 0);
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [241:0] mk(input logic [1:0] op, input logic [15:0] n1,
                                      input logic [15:0] n2, input logic [15:0] base);
    logic [241:0] e;
    e = '0;
    e[0   +: 16] = base;
    e[16  +: 16] = 16'(base + 3);
    e[32  +: 16] = 16'(base * 2);
    e[48  +: 16] = 16'(base * 2 + 4);
    e[64  +: 16] = 16'(base + 1);
    e[80  +: 16] = 16'(base + 9);
    e[96  +: 16] = 16'(base * 3);
    e[112 +: 16] = 16'(base * 3 + 5);
    e[128 +: 16] = 16'(base + 7);
    e[144 +: 16] = 16'(base + 8);
    e[160 +: 16] = 16'(base + 11);
    e[176 +: 16] = 16'(base + 12);
    e[193:192]   = op;
    e[194 +: 16] = n1;
    e[210 +: 16] = n2;
    e[226 +: 16] = 16'h5A5A;
    return e;
  endfunction

  // Scoreboard: every accepted task is compared against the next expectation.
  always @(negedge clk) begin
    if (!reset && task_valid && task_ready) begin
      if (exp_q.size() == 0) begin
        chk("spurious_task", 128'(exp_q.size()), 128'd1);
      end else begin
        exp_t e;
        logic [241:0] ent;
        logic [15:0] rows, inner, cols;
        e = exp_q.pop_front();
        ent = mem[e.node[5:0]];
        rows  = ent[16 +: 16] - ent[0 +: 16] + 16'd1;
        inner = ent[48 +: 16] - ent[32 +: 16] + 16'd1;
        cols  = ent[112 +: 16] - ent[96 +: 16] + 16'd1;
        chk("task_node", task_node, e.node);
        chk("task_acc", task_acc, e.acc);
        chk("task_origin", {task_a_row0, task_a_col0, task_b_row0, task_b_col0, task_o_row0, task_o_col0},
            {ent[0 +: 16], ent[32 +: 16], ent[64 +: 16], ent[96 +: 16], ent[128 +: 16], ent[160 +: 16]});
        chk("task_dims", {task_rows, task_inner, task_cols}, {rows, inner, cols});
      end
    end
  end

  task automatic clear_mem();
    for (int i = 0; i < 64; i++) mem[i] = mk(NONE, 16'd0, 16'd0, 16'(i * 7));
  endtask

  task automatic push_exp(input logic [15:0] node, input logic acc);
    exp_t e;
    e.node = node;
    e.acc  = acc;
    exp_q.push_back(e);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done();
    int c = 0;
    while (!done && c < 3000) begin
      @(posedge clk); #1;
      c++;
    end
    chk("done_timeout", 128'(c < 3000), 128'd1);
  endtask

  task automatic end_checks(input string tag, input logic err, input logic [15:0] leaves);
    chk({tag, "_done"}, {done, busy}, {1'b1, 1'b0});
    chk({tag, "_error"}, error, err);
    chk({tag, "_leaf_count"}, leaf_count, leaves);
    chk({tag, "_sb_empty"}, 128'(exp_q.size()), 128'd0);
  endtask

  initial begin
    int cyc;
    clear_mem();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {task_valid, busy, done, error, leaf_count, tbl_addr}, '0);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;

    // Single root leaf, latency start+3
    mem[0] = mk(NONE, 16'd0, 16'd0, 16'd0);
    split_last = 16'd1;
    push_exp(16'd0, 1'b0);
    pulse_start();
    cyc = 1;
    while (!task_valid && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("root_leaf_latency", cyc, 3);
    chk("root_leaf_dims", {task_rows, task_inner, task_cols}, {16'd4, 16'd5, 16'd6});
    wait_done();
    end_checks("single", 1'b0, 16'd1);

    // Vertical split with backpressure on the first task
    clear_mem();
    mem[0] = mk(VERT, 16'd1, 16'd2, 16'd100);
    split_last = 16'd3;
    push_exp(16'd1, 1'b0);
    push_exp(16'd2, 1'b0);
    task_ready = 1'b0;
    pulse_start();
    cyc = 0;
    while (!task_valid && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("vert_first_valid", task_valid, 1'b1);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        pulse_start();
      end else begin
        @(posedge clk); #1;
      end
      chk("bp_hold", {task_valid, task_node, task_rows, task_a_row0, tbl_addr, leaf_count},
          {1'b1, 16'd1, 16'd4, 16'd7, 16'd1, 16'd0});
    end
    task_ready = 1'b1;
    wait_done();
    end_checks("vert", 1'b0, 16'd2);

    // Sum over a horizontal split, random backpressure, wrapped geometry
    clear_mem();
    mem[0] = mk(SUM, 16'd1, 16'd2, 16'd0);
    mem[2] = mk(HOR, 16'd3, 16'd4, 16'd0);
    mem[4] = mk(NONE, 16'd0, 16'd0, 16'hFFFE);
    split_last = 16'd5;
    push_exp(16'd1, 1'b0);
    push_exp(16'd3, 1'b1);
    push_exp(16'd4, 1'b1);
    rand_ready = 1'b1;
    pulse_start();
    wait_done();
    rand_ready = 1'b0;
    @(posedge clk); #1;
    task_ready = 1'b1;
    end_checks("sum_hor", 1'b0, 16'd3);

    // Deepest chain that fits: 15 internal nodes
    clear_mem();
    for (int i = 0; i < 15; i++) mem[i] = mk(VERT, 16'(i + 1), 16'd20, 16'(i));
    split_last = 16'd21;
    push_exp(16'd15, 1'b0);
    for (int i = 0; i < 15; i++) push_exp(16'd20, 1'b0);
    rand_ready = 1'b1;
    pulse_start();
    wait_done();
    rand_ready = 1'b0;
    @(posedge clk); #1;
    task_ready = 1'b1;
    end_checks("chain15", 1'b0, 16'd16);

    // One more internal level overflows the stack before any leaf
    mem[15] = mk(VERT, 16'd16, 16'd20, 16'd15);
    pulse_start();
    wait_done();
    end_checks("overflow", 1'b1, 16'd0);

    // Bad child index
    clear_mem();
    mem[0] = mk(VERT, 16'd1, 16'd7, 16'd0);
    split_last = 16'd5;
    pulse_start();
    wait_done();
    end_checks("bad_child", 1'b1, 16'd0);

    // Root beyond split_last
    split_last = 16'd0;
    pulse_start();
    wait_done();
    end_checks("bad_root", 1'b1, 16'd0);

    // Reset while a task waits in EMIT
    clear_mem();
    split_last = 16'd1;
    task_ready = 1'b0;
    pulse_start();
    cyc = 0;
    while (!task_valid && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("emit_reached", task_valid, 1'b1);
    reset = 1'b1;
    #2;
    chk("async_reset", {task_valid, busy, done, error, leaf_count, tbl_addr}, '0);
    @(negedge clk) reset = 1'b0;
    task_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("after_reset_idle", {task_valid, busy, done}, 3'b000);

    // start ignored without split_ready
    split_ready = 1'b0;
    pulse_start();
    repeat (3) @(posedge clk);
    #1;
    chk("gated_start", {busy, done, task_valid}, 3'b000);
    split_ready = 1'b1;
    chk("final_sb_empty", 128'(exp_q.size()), 128'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/sys_array_leaf_scheduler.md
Name: sys_array_leaf_scheduler

Overview:
- Sits directly downstream of the split-table generator.
- Walks the finished split tree (split_type entries) depth-first from root node 0, children to_n1 before to_n2.
- Emits one tile task per leaf entry (operation == connect_none) to the systolic array controller over a valid/ready handshake.
- Tags each task with an accumulate flag so partial sums from connect_sum splits are added into the output region, not overwritten.

Parameters:
- TABLE_SIZE, 100, number of split-table entries addressable.
- STACK_DEPTH, 16, DFS stack entries, each 17 bits (node index 16 + acc 1).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  begin traversal (pulse)
- split_ready  in  1  split table complete
- split_last  in  16  number of valid table entries
- tbl_addr  out  16  table read index
- tbl_rdata  in  split_type  entry at tbl_addr, valid one cycle after tbl_addr is driven
- task_valid  out  1  task available
- task_ready  in  1  consumer accepts task
- task_node  out  16  leaf index
- task_a_row0, task_a_col0, task_b_row0, task_b_col0, task_o_row0, task_o_col0  out  16 each  A_W_0, A_L_0, B_W_0, B_L_0, O_W_0, O_L_0 of the leaf, verbatim
- task_rows, task_inner, task_cols  out  16 each  A_W_1-A_W_0+1, A_L_1-A_L_0+1, B_L_1-B_L_0+1, modulo 2^16
- task_acc  out  1  accumulate into the output region
- busy  out  1  traversal in progress
- done  out  1  traversal finished (held)
- error  out  1  overflow or bad index (held)
- leaf_count  out  16  tasks accepted in this traversal

Behaviour:
- Reset (async, reset=1): state IDLE, stack empty, all outputs 0, tbl_addr 0.
- States: IDLE, POP, EVAL, EMIT, DONE.
- IDLE: start=1 and split_ready=1 triggers a traversal.
  - Push {0, acc=0}.
  - Clear done, error and leaf_count.
  - Set busy=1, go to POP.
  - start with split_ready=0 is ignored.
- POP:
  - Stack empty: go to DONE.
  - Otherwise pop the top, drive tbl_addr=index, register acc, go to EVAL.
- EVAL: tbl_rdata is valid in this cycle.
  - Index >= split_last: error=1, go to DONE.
  - operation == connect_none: register all task fields and task_acc=acc, set task_valid=1, go to EMIT.
  - Any other operation:
    - If to_n1 >= split_last or to_n2 >= split_last: error=1, go to DONE.
    - Else if the stack holds more than STACK_DEPTH-2 entries: error=1, go to DONE.
    - Else push {to_n2, acc | (operation == connect_sum)}, then push {to_n1, acc}, so to_n1 is on top. Go to POP.
- EMIT:
  - task fields and task_valid stay stable while task_ready=0.
  - On task_valid & task_ready: task_valid=0, leaf_count+1, go to POP.
- DONE:
  - busy=0, done=1. done and error hold until the next accepted start.
  - start in DONE behaves as in IDLE.
- start while busy is ignored.
- Latency: a start accepted at cycle t gives task_valid at t+3 for a root leaf. Each internal node costs 2 cycles; each leaf costs 2 cycles plus the handshake.
- Reset during any state aborts immediately: task_valid drops asynchronously and no further tasks are emitted.
- Arithmetic: all 16-bit unsigned, wrap-around allowed, no saturation. The parent field is not used.

Test Plan:
- Single leaf: split_last=1, entry0 none, A_W 0..3, A_L 0..4, B_L 0..5, task_ready=1 → task_valid at start+3, node 0, rows=4, inner=5, cols=6, acc=0; then done=1, leaf_count=1.
- Vertical split: root connect_vert with children 1 and 2 (both none), split_last=3 → tasks in order node1, node2; acc 0, 0; leaf_count=2.
- Sum/horizontal mix:
  - Root connect_sum, to_n1=1 (none), to_n2=2 (connect_hor).
  - Node 2 has to_n1=3 and to_n2=4 (both none); split_last=5.
  - Required: tasks in order 1, 3, 4 with acc 0, 1, 1.
- Backpressure: task_ready=0 for 5 cycles while task_valid=1 → all task fields unchanged, leaf_count unchanged, no tbl_addr change; accepted on the first ready cycle.
- Overflow: STACK_DEPTH=2, root split, node 1 split → error=1 and done=1 in the EVAL of node 1; no task emitted.
- Reset and gating:
  - reset pulse in EMIT → task_valid=0, busy=0, state IDLE.
  - start with split_ready=0 → busy stays 0.
  - Child index 7 with split_last=5 → error=1.
